// File: rtl/video_vga_linebuf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_vga_linebuf_ctrl_pkg
// Brief    : Shared constants and read-FSM encoding for the line-buffer control.
// Revision : 1.0
// ============================================================================
package video_vga_linebuf_ctrl_pkg;

    localparam int LINE_LEN_DEF = 720;
    localparam int RD_LATENCY   = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/video_vga_lb_cnt.sv
`default_nettype none
// ============================================================================
// Module   : video_vga_lb_cnt
// Brief    : Address counter that clears, increments and saturates at LIMIT.
// Revision : 1.0
// ============================================================================
module video_vga_lb_cnt #(
    parameter int W     = 10,
    parameter int LIMIT = 720
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LIMIT_W);

    // clr has priority so a restart on the terminal cycle lands on zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !tc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_vga_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_vga_linebuf_ctrl
// Brief    : Ping-pong line-buffer sequencer for the TV-to-VGA scan doubler.
// Revision : 1.0
// ============================================================================
module video_vga_linebuf_ctrl
    import video_vga_linebuf_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int LINE_LEN = LINE_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsync_start,
    input  logic              wr_stb,
    input  logic              scanout_start,
    input  logic              scanlines_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_bank,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    output logic              pix_valid,
    output logic              pix_dim,
    output logic              ovr
);

    rd_state_e state_q, state_d;
    logic      wr_bank_q, wr_bank_d;
    logic      pass_q, pass_d;
    logic      rd_bank_q, rd_bank_d;
    logic      dim_pass_q, dim_pass_d;
    logic      pix_valid_q, pix_dim_q;

    logic w_scan;
    logic w_wr_tc;
    logic w_rd_tc;
    logic w_wr_inc;
    logic w_rd_clr;
    logic w_pass_done;

    assign w_scan      = (state_q == ST_SCAN);
    // swap beats a coincident pixel; nothing is written once the line is full
    assign w_wr_inc    = wr_stb && !hsync_start && !w_wr_tc && !rst;
    assign w_pass_done = w_scan && w_rd_tc && !scanout_start;
    assign w_rd_clr    = scanout_start || (w_scan && w_rd_tc);

    video_vga_lb_cnt #(
        .W     (ADDR_W),
        .LIMIT (LINE_LEN)
    ) u_wr_cnt (
        .clk (clk),
        .rst (rst),
        .clr (hsync_start),
        .inc (w_wr_inc),
        .cnt (wr_addr),
        .tc  (w_wr_tc)
    );

    video_vga_lb_cnt #(
        .W     (ADDR_W),
        .LIMIT (LINE_LEN - 1)
    ) u_rd_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_rd_clr),
        .inc (w_scan),
        .cnt (rd_addr),
        .tc  (w_rd_tc)
    );

    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q ^ hsync_start;
        pass_d     = pass_q;
        rd_bank_d  = rd_bank_q;
        dim_pass_d = dim_pass_q;

        case (state_q)
            ST_IDLE: if (scanout_start) state_d = ST_SCAN;
            ST_SCAN: if (w_pass_done)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (hsync_start) begin
            pass_d = 1'b0;
        end else if (w_pass_done) begin
            pass_d = ~pass_q;
        end

        // a pass starting with a new TV line reads the bank just filled
        if (scanout_start) begin
            rd_bank_d  = ~wr_bank_d;
            dim_pass_d = pass_q && !hsync_start && scanlines_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_bank_q  <= 1'b0;
            pass_q     <= 1'b0;
            rd_bank_q  <= 1'b0;
            dim_pass_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            pass_q     <= pass_d;
            rd_bank_q  <= rd_bank_d;
            dim_pass_q <= dim_pass_d;
        end
    end

    // Tracks RAM read latency; unreset so pix_valid trails rd_en by one clk on reset too
    always_ff @(posedge clk) begin
        pix_valid_q <= w_scan;
        pix_dim_q   <= w_scan && dim_pass_q;
    end

    assign wr_en     = w_wr_inc;
    assign wr_bank   = wr_bank_q;
    assign rd_en     = w_scan;
    assign rd_bank   = rd_bank_q;
    assign pix_valid = pix_valid_q;
    assign pix_dim   = pix_dim_q;
    assign ovr       = scanout_start && w_scan && !rst;

endmodule
`default_nettype wire

// File: tb/tb_video_vga_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_vga_linebuf_ctrl
// Brief    : Randomized and directed bench against a line-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_video_vga_linebuf_ctrl;

    localparam int ADDR_W = 10;
    localparam int LEN    = 720;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              hsync_start = 1'b0;
    logic              wr_stb = 1'b0;
    logic              scanout_start = 1'b0;
    logic              scanlines_en = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_bank;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_bank;
    logic              pix_valid;
    logic              pix_dim;
    logic              ovr;

    video_vga_linebuf_ctrl #(
        .ADDR_W   (ADDR_W),
        .LINE_LEN (LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hsync_start   (hsync_start),
        .wr_stb        (wr_stb),
        .scanout_start (scanout_start),
        .scanlines_en  (scanlines_en),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_bank       (wr_bank),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_bank       (rd_bank),
        .pix_valid     (pix_valid),
        .pix_dim       (pix_dim),
        .ovr           (ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_steps  = 0;
    bit se_v     = 1'b0;

    // model state: line-level view of the scan doubler
    int m_wr_addr = 0;
    bit m_wr_bank = 0;
    bit m_pass    = 0;
    bit m_scan    = 0;
    int m_rd_pos  = 0;
    bit m_rd_bank = 0;
    bit m_dim     = 0;
    bit m_prev_en = 0;
    bit m_prev_dim = 0;

    // activity counters of DUT outputs for literal checks
    int c_rd_en = 0, c_pv = 0, c_dim = 0, c_ovr = 0, c_wr_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clr_counts();
        c_rd_en = 0; c_pv = 0; c_dim = 0; c_ovr = 0; c_wr_en = 0;
    endtask

    task automatic step(input bit hs, input bit ws, input bit ss, input bit rs);
        bit e_wr_en, e_ovr, nb;
        hsync_start   = hs;
        wr_stb        = ws;
        scanout_start = ss;
        rst           = rs;
        scanlines_en  = se_v;
        #2;
        e_wr_en = ws && !hs && !rs && (m_wr_addr < LEN);
        e_ovr   = ss && m_scan && !rs;
        if (n_steps >= 2) begin
            chk("wr_en", int'(wr_en), int'(e_wr_en));
            chk("wr_addr", int'(wr_addr), m_wr_addr);
            chk("wr_bank", int'(wr_bank), int'(m_wr_bank));
            chk("rd_en", int'(rd_en), int'(m_scan));
            if (m_scan) begin
                chk("rd_addr", int'(rd_addr), m_rd_pos);
                chk("rd_bank", int'(rd_bank), int'(m_rd_bank));
            end
            chk("pix_valid", int'(pix_valid), int'(m_prev_en));
            chk("pix_dim", int'(pix_dim), int'(m_prev_en && m_prev_dim));
            chk("ovr", int'(ovr), int'(e_ovr));
        end
        c_rd_en += int'(rd_en);
        c_pv    += int'(pix_valid);
        c_dim   += int'(pix_dim);
        c_ovr   += int'(ovr);
        c_wr_en += int'(wr_en);

        m_prev_en  = m_scan;
        m_prev_dim = m_dim;
        if (rs) begin
            m_wr_addr = 0; m_wr_bank = 0; m_pass = 0; m_scan = 0;
            m_rd_pos = 0; m_rd_bank = 0; m_dim = 0;
        end else begin
            nb = hs ? !m_wr_bank : m_wr_bank;
            if (hs)           m_wr_addr = 0;
            else if (e_wr_en) m_wr_addr++;
            if (hs)
                m_pass = 0;
            else if (m_scan && m_rd_pos == LEN - 1 && !ss)
                m_pass = !m_pass;
            if (ss) begin
                m_dim     = (hs ? 1'b0 : m_pass) && se_v;
                m_scan    = 1;
                m_rd_pos  = 0;
                m_rd_bank = !nb;
            end else if (m_scan) begin
                if (m_rd_pos == LEN - 1) m_scan = 0;
                else                     m_rd_pos++;
            end
            m_wr_bank = nb;
        end
        n_steps++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        bit b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // idle after reset
        clr_counts();
        run(2000);
        chk("idle_rd_en_cnt", c_rd_en, 0);
        chk("idle_wr_en_cnt", c_wr_en, 0);
        chk("idle_ovr_cnt", c_ovr, 0);
        chk("idle_pv_cnt", c_pv, 0);
        chk("idle_wr_bank", int'(wr_bank), 0);

        // fill one line, then overflow by one pixel
        step(1, 0, 0, 0);
        clr_counts();
        for (int i = 0; i < LEN; i++) begin
            step(0, 1, 0, 0);
            step(0, 0, 0, 0);
        end
        chk("fill_wr_en_cnt", c_wr_en, 720);
        chk("fill_wr_addr", int'(wr_addr), 720);
        step(0, 1, 0, 0);
        chk("fill_extra_addr", int'(wr_addr), 720);
        chk("fill_wr_bank", int'(wr_bank), 1);

        // single pass latency and length
        clr_counts();
        step(0, 0, 1, 0);
        chk("scan_first_en", int'(rd_en), 1);
        chk("scan_first_addr", int'(rd_addr), 0);
        chk("scan_first_pv", int'(pix_valid), 0);
        chk("scan_rd_bank", int'(rd_bank), 0);
        run(725);
        chk("scan_rd_en_cnt", c_rd_en, 720);
        chk("scan_pv_cnt", c_pv, 720);

        // two passes per TV line, with and without scanline dimming
        se_v = 1;
        step(1, 0, 0, 0);
        clr_counts();
        step(0, 0, 1, 0); run(722);
        chk("dim_pass1", c_dim, 0);
        clr_counts();
        step(0, 0, 1, 0); run(722);
        chk("dim_pass2", c_dim, 720);
        se_v = 0;
        step(1, 0, 0, 0);
        clr_counts();
        step(0, 0, 1, 0); run(722);
        step(0, 0, 1, 0); run(722);
        chk("nodim_both", c_dim, 0);

        // bank swap mid-pass, then simultaneous swap and scanout
        step(0, 0, 1, 0);
        run(300);
        b0 = rd_bank;
        step(1, 0, 0, 0);
        run(421);
        chk("swap_rd_bank_kept", int'(rd_bank), int'(b0));
        run(5);
        b0 = m_wr_bank;
        step(1, 0, 1, 0);
        chk("swap_sim_rd_bank", int'(rd_bank), int'(b0));
        run(725);

        // restart mid-pass
        clr_counts();
        step(0, 0, 1, 0);
        run(500);
        step(0, 0, 1, 0);
        run(725);
        chk("ovr_cnt", c_ovr, 1);
        chk("restart_rd_en_cnt", c_rd_en, 1221);

        // reset mid-pass
        step(0, 0, 1, 0);
        run(100);
        step(0, 0, 0, 1);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_pv_lag", int'(pix_valid), 1);
        step(0, 0, 0, 0);
        chk("rst_pv_drop", int'(pix_valid), 0);

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            if (i % 500 == 0) se_v = 1'($urandom_range(0, 1));
            step($urandom_range(0, 899) == 0, $urandom_range(0, 1) == 0,
                 $urandom_range(0, 399) == 0, $urandom_range(0, 2999) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
